// File: rtl/arrow_raster_indexer.sv
// Arrow raster indexer: walks the raster in step with pix_valid and
// produces a colour-palette index per consumed pixel for a multi-player
// lane display. The display has three bands:
//   - a scrolling arrow field
//   - a static target band
//   - a bottom judgement panel
// Counters are purely incremental, so no divide or multiply hardware is used.
module arrow_raster_indexer #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int N_PLAYERS    = 2,
  parameter int N_LANES      = 5,
  parameter int N_SLOTS      = 26,
  parameter int SLOT_H       = 16,
  parameter int LANE_H       = 64,
  parameter int PANEL_H      = 48,
  parameter int FLASH_FRAMES = 30,
  parameter logic [3*N_LANES-1:0] LANE_CODES  = {3'b100, 3'b011, 3'b001, 3'b010, 3'b110},
  parameter logic [8*N_LANES-1:0] LANE_COLORS = {8'd5, 8'd7, 8'd6, 8'd4, 8'd8}
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             pix_valid,
  input  logic [3*N_SLOTS*N_PLAYERS-1:0]   arrow_array,
  input  logic [2*N_PLAYERS-1:0]           indicator,
  input  logic [N_PLAYERS-1:0]             indicator_load,
  output logic [7:0]                       index,
  output logic                             index_valid,
  output logic                             frame_done
);

  localparam int FIELD_W    = SCREEN_W / N_PLAYERS;
  localparam int LANE_W     = SCREEN_W / (N_PLAYERS * N_LANES);
  localparam int ARROW_END  = SCREEN_H - PANEL_H - LANE_H;
  localparam int BAND_END   = SCREEN_H - PANEL_H;
  localparam int ARROW_BITS = 3 * N_SLOTS * N_PLAYERS;

  localparam int XW  = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int YW  = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam int PW  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int LNW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int FXW = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;
  localparam int LXW = (LANE_W > 1) ? $clog2(LANE_W) : 1;
  localparam int SRW = (SLOT_H > 1) ? $clog2(SLOT_H) : 1;
  localparam int CW  = $clog2(FLASH_FRAMES + 1);

  // Raster position and derived field/lane/slot coordinates
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [PW-1:0]  player;
  logic [FXW-1:0] local_x;
  logic [LNW-1:0] lane;
  logic [LXW-1:0] lane_x;
  logic [YW-1:0]  slot;
  logic [SRW-1:0] slot_row;

  logic                  frame_wrap;
  logic                  fresh;
  logic [ARROW_BITS-1:0] shadow;
  logic [ARROW_BITS-1:0] render_arrows;

  logic [1:0]    ind_q     [N_PLAYERS];
  logic [CW-1:0] flash_cnt [N_PLAYERS];

  logic [2:0] lane_code;
  logic [7:0] lane_color;
  logic       arrow_hit;
  logic [1:0] cur_ind;
  logic [7:0] pix_index;

  logic       s1_valid;
  logic [7:0] s1_index;

  assign frame_wrap = pix_valid
                    && (x == XW'(SCREEN_W - 1))
                    && (y == YW'(SCREEN_H - 1));

  // The shadow reads as zero until the first cycle after reset. In that
  // cycle the live arrow_array is rendered directly, so a pixel consumed
  // right at reset release already sees the freshly captured frame data.
  assign render_arrows = fresh ? arrow_array : shadow;

  // Raster walk: every coordinate is a small counter that wraps at its
  // boundary, so player/lane/slot never need a division.
  always_ff @(posedge clock) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      player   <= '0;
      local_x  <= '0;
      lane     <= '0;
      lane_x   <= '0;
      slot     <= '0;
      slot_row <= '0;
    end else if (pix_valid) begin
      if (x == XW'(SCREEN_W - 1)) begin
        x       <= '0;
        player  <= '0;
        local_x <= '0;
        lane    <= '0;
        lane_x  <= '0;
        if (y == YW'(SCREEN_H - 1)) begin
          y        <= '0;
          slot     <= '0;
          slot_row <= '0;
        end else begin
          y <= y + YW'(1);
          if (slot_row == SRW'(SLOT_H - 1)) begin
            slot_row <= '0;
            slot     <= slot + YW'(1);
          end else begin
            slot_row <= slot_row + SRW'(1);
          end
        end
      end else begin
        x <= x + XW'(1);
        if (local_x == FXW'(FIELD_W - 1)) begin
          local_x <= '0;
          player  <= player + PW'(1);
          lane    <= '0;
          lane_x  <= '0;
        end else begin
          local_x <= local_x + FXW'(1);
          if (lane_x == LXW'(LANE_W - 1)) begin
            lane_x <= '0;
            lane   <= lane + LNW'(1);
          end else begin
            lane_x <= lane_x + LXW'(1);
          end
        end
      end
    end
  end

  // Arrow shadow: captured once after reset and again at each frame wrap.
  // This keeps a frame from tearing when arrow_array changes mid-frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow <= '0;
      fresh  <= 1'b1;
    end else begin
      fresh <= 1'b0;
      if (fresh || frame_wrap) begin
        shadow <= arrow_array;
      end
    end
  end

  // Judgement flash: a load restarts the countdown and wins over a
  // coincident wrap; otherwise each wrap burns one frame of display time.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < N_PLAYERS; p++) begin
        ind_q[p]     <= 2'b00;
        flash_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < N_PLAYERS; p++) begin
        if (indicator_load[p]) begin
          ind_q[p]     <= indicator[2*p +: 2];
          flash_cnt[p] <= CW'(FLASH_FRAMES);
        end else if (frame_wrap && (flash_cnt[p] != '0)) begin
          flash_cnt[p] <= flash_cnt[p] - CW'(1);
        end
      end
    end
  end

  // Pixel colour for the current raster position. Arrow hits are
  // evaluated against a four-slot window ending at the current slot,
  // which makes each arrow appear four slots tall.
  always_comb begin
    lane_code  = 3'b000;
    lane_color = 8'd0;
    arrow_hit  = 1'b0;
    cur_ind    = 2'b00;
    pix_index  = 8'd0;

    for (int l = 0; l < N_LANES; l++) begin
      if (int'(lane) == l) begin
        lane_code  = LANE_CODES[3*l +: 3];
        lane_color = LANE_COLORS[8*l +: 8];
      end
    end

    for (int p = 0; p < N_PLAYERS; p++) begin
      for (int s = 0; s < N_SLOTS; s++) begin
        if ((int'(player) == p)
            && (int'(slot) >= s)
            && (int'(slot) <= s + 3)
            && (render_arrows[3*(p*N_SLOTS + s) +: 3] == lane_code)) begin
          arrow_hit = 1'b1;
        end
      end
      if (int'(player) == p) begin
        cur_ind = (flash_cnt[p] != '0) ? ind_q[p] : 2'b00;
      end
    end

    if (y < YW'(ARROW_END)) begin
      pix_index = arrow_hit ? lane_color : 8'd0;
    end else if (y < YW'(BAND_END)) begin
      pix_index = lane_color;
    end else begin
      case (cur_ind)
        2'b11:   pix_index = 8'd1;
        2'b10:   pix_index = 8'd2;
        2'b01:   pix_index = 8'd3;
        default: pix_index = 8'd0;
      endcase
    end
  end

  // Two-stage output pipeline.
  // The colour is registered at the consuming edge, then retimed once more.
  // frame_done follows the wrap by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_index    <= 8'd0;
      index_valid <= 1'b0;
      index       <= 8'd0;
      frame_done  <= 1'b0;
    end else begin
      s1_valid    <= pix_valid;
      s1_index    <= pix_valid ? pix_index : 8'd0;
      index_valid <= s1_valid;
      index       <= s1_index;
      frame_done  <= frame_wrap;
    end
  end

endmodule
